regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (w_addr/din) between two writeback sources: ALU and LSU.
//  Sits between the execute/memory stages and regfile; arbitrates, registers the winner and drives the port.
//  Fixed LSU priority with an ALU starvation guard; w_addr=0 on the port means "no write".
// PARAMETERS
//  DATA_WIDTH    `DATA_WIDTH (32)  width of writeback data
//  STARVE_LIMIT  3                 consecutive ALU losses before the ALU is forced to win (>=1)
//  CNT_W         2                 width of starvation counter; must hold STARVE_LIMIT
// PORTS
//  clk_i          in   1           single clock; all state updates on posedge
//  rst_i          in   1           synchronous reset, active-high
//  alu_valid_i    in   1           ALU writeback request
//  alu_rd_i       in   5           ALU destination register
//  alu_data_i     in   DATA_WIDTH  ALU result
//  alu_ready_o    out  1           ALU request accepted this cycle
//  lsu_valid_i    in   1           LSU (load) writeback request
//  lsu_rd_i       in   5           LSU destination register
//  lsu_data_i     in   DATA_WIDTH  load data
//  lsu_ready_o    out  1           LSU request accepted this cycle
//  w_addr_o       out  5           to regfile write address; 0 = no write
//  din_o          out  DATA_WIDTH  to regfile write data
//  grant_src_o    out  2           registered source of current w_addr_o: 0 none, 1 ALU, 2 LSU
//  starve_cnt_o   out  CNT_W       current ALU starvation count (debug)
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge): w_addr_o=0, din_o=0, grant_src_o=0, starve_cnt=0; while rst_i=1 both ready=0.
//  - Effective request: X_req = X_valid_i & (X_rd_i != 0).
//  - valid with rd=0: ready=1 same cycle, consumed, no port write, not counted as contention.
//  - Only one effective request: it is granted, ready=1.
//  - Both effective: LSU wins, ALU ready=0; exception: starve_cnt==STARVE_LIMIT -> ALU wins, LSU ready=0.
//  - starve_cnt: +1 (saturating at STARVE_LIMIT) when alu_req & ~alu grant; cleared when ALU is granted or alu_req=0.
//  - ready_o is combinational from valids/rd/starve_cnt. Requesters hold valid+payload stable until ready=1.
//    They must not gate valid on ready.
//  - Grant registered: posedge after handshake, w_addr_o<=rd, din_o<=data, grant_src_o<=src.
//    No grant -> w_addr_o<=0, din_o<=0, grant_src_o<=0.
//  - Latency: handshake cycle N -> port driven cycle N+1 -> regfile commits at end of N+1 (its bypass covers N+1 reads).
//  - Throughput: one write per cycle, no stall from the regfile side (port always accepts).
//  - Same nonzero rd on both: winner written first, loser next grant -> loser's value persists.
//    Ordering across sources is the issuing stage's responsibility.
//  - Reset mid-operation: registered write in flight is dropped (w_addr_o=0 next cycle); pending requests not retained.
//  - X/Z on rd with valid=0 must not affect outputs.
// STRUCTURE
//  - proc_pkg: typedef enum logic[1:0] {WB_NONE=0, WB_ALU=1, WB_LSU=2} wb_src_e; localparam REG_ADDR_W=5.
//  - Flat module: comb arbiter + one always_ff for output regs and starve counter; no sub-module.
// TESTING
//  - Reset: hold rst_i 2 cycles with both valid -> ready=0, w_addr_o=0, din_o=0, grant_src_o=0.
//  - Single ALU: alu rd=5 data=0x1234 -> alu_ready=1; next cycle w_addr_o=5, din_o=0x1234, grant_src_o=1.
//  - Contention: ALU rd=1, LSU rd=2 both held valid -> LSU granted; with new LSU reqs each cycle,
//    ALU granted on 4th cycle (STARVE_LIMIT=3), starve_cnt_o 0,1,2,3,0.
//  - rd=0: alu rd=0 with lsu rd=7 -> both ready=1 same cycle; next cycle w_addr_o=7, grant_src_o=2.
//  - Same rd: both rd=9, lsu=0xAA, alu=0xBB -> port 9/0xAA then 9/0xBB; regfile r9 reads 0xBB afterwards.
//  - Mid-op reset: grant in cycle N, rst_i=1 in N+1 -> w_addr_o=0 at N+2, starve_cnt_o=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared writeback definitions: source encoding and register-address width.
package proc_pkg;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LSU  = 2'd2
  } wb_src_e;

  localparam int unsigned REG_ADDR_W = 5;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter in front of the single regfile write port.
// LSU has fixed priority; after STARVE_LIMIT consecutive ALU losses the ALU
// is forced through. The winner is registered and driven onto the port the
// following cycle; w_addr_o == 0 means no write.
module regfile_wb_arbiter
  import proc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned CNT_W        = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_rd_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  output logic                  alu_ready_o,
  input  logic                  lsu_valid_i,
  input  logic [REG_ADDR_W-1:0] lsu_rd_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,
  output logic                  lsu_ready_o,
  output logic [REG_ADDR_W-1:0] w_addr_o,
  output logic [DATA_WIDTH-1:0] din_o,
  output logic [1:0]            grant_src_o,
  output logic [CNT_W-1:0]      starve_cnt_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic                  alu_req;
  logic                  lsu_req;
  logic                  alu_force;
  logic                  alu_win;
  logic                  lsu_win;
  logic [CNT_W-1:0]      starve_cnt;
  logic [REG_ADDR_W-1:0] w_addr;
  logic [DATA_WIDTH-1:0] din;
  wb_src_e               grant_src;

  // Arbitration and combinational handshake. A valid with rd == 0 is
  // accepted immediately but never competes for the port.
  always_comb begin
    alu_req     = alu_valid_i & (alu_rd_i != '0);
    lsu_req     = lsu_valid_i & (lsu_rd_i != '0);
    alu_force   = (starve_cnt == LIMIT);
    alu_win     = alu_req & (~lsu_req | alu_force);
    lsu_win     = lsu_req & ~alu_win;
    alu_ready_o = ~rst_i & alu_valid_i & ((alu_rd_i == '0) | alu_win);
    lsu_ready_o = ~rst_i & lsu_valid_i & ((lsu_rd_i == '0) | lsu_win);
  end

  // Registered port drive and ALU starvation counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_addr     <= '0;
      din        <= '0;
      grant_src  <= WB_NONE;
      starve_cnt <= '0;
    end else begin
      if (alu_win) begin
        w_addr    <= alu_rd_i;
        din       <= alu_data_i;
        grant_src <= WB_ALU;
      end else if (lsu_win) begin
        w_addr    <= lsu_rd_i;
        din       <= lsu_data_i;
        grant_src <= WB_LSU;
      end else begin
        w_addr    <= '0;
        din       <= '0;
        grant_src <= WB_NONE;
      end

      if (alu_req & ~alu_win) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  assign w_addr_o     = w_addr;
  assign din_o        = din;
  assign grant_src_o  = grant_src;
  assign starve_cnt_o = starve_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios plus random
// traffic obeying the hold-until-ready protocol.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int SL = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          alu_valid_i, lsu_valid_i;
  logic [4:0]    alu_rd_i, lsu_rd_i;
  logic [DW-1:0] alu_data_i, lsu_data_i;
  logic          alu_ready_o, lsu_ready_o;
  logic [4:0]    w_addr_o;
  logic [DW-1:0] din_o;
  logic [1:0]    grant_src_o;
  logic [CW-1:0] starve_cnt_o;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(SL),
    .CNT_W       (CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .alu_valid_i (alu_valid_i),
    .alu_rd_i    (alu_rd_i),
    .alu_data_i  (alu_data_i),
    .alu_ready_o (alu_ready_o),
    .lsu_valid_i (lsu_valid_i),
    .lsu_rd_i    (lsu_rd_i),
    .lsu_data_i  (lsu_data_i),
    .lsu_ready_o (lsu_ready_o),
    .w_addr_o    (w_addr_o),
    .din_o       (din_o),
    .grant_src_o (grant_src_o),
    .starve_cnt_o(starve_cnt_o)
  );

  typedef struct {
    logic [4:0]    addr;
    logic [DW-1:0] data;
    logic [1:0]    src;
  } wr_t;

  wr_t           exp_q[$];
  int            tests = 0;
  int            fails = 0;
  int            losses = 0;   // consecutive cycles the ALU asked and lost
  logic [DW-1:0] port_rf[32];  // regfile image built from port writes

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive, check handshake and starvation count
  // against the reference model, push the expected port contents.
  task automatic step(input logic r,
                      input logic av, input logic [4:0] ard, input logic [DW-1:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [DW-1:0] ld,
                      output logic ar, output logic lr);
    bit  areq, lreq, awin, lwin, exp_ar, exp_lr;
    wr_t e;
    @(negedge clk);
    rst_i = r;
    alu_valid_i = av; alu_rd_i = ard; alu_data_i = ad;
    lsu_valid_i = lv; lsu_rd_i = lrd; lsu_data_i = ld;
    #1;
    areq = av && (ard != 0);
    lreq = lv && (lrd != 0);
    if (areq && lreq) awin = (losses >= SL);
    else awin = areq;
    lwin = lreq && !awin;
    exp_ar = !r && av && ((ard == 0) || awin);
    exp_lr = !r && lv && ((lrd == 0) || lwin);
    check("starve_cnt", 64'(starve_cnt_o), 64'(losses));
    check("alu_ready", 64'(alu_ready_o), 64'(exp_ar));
    check("lsu_ready", 64'(lsu_ready_o), 64'(exp_lr));
    e.addr = 5'd0; e.data = '0; e.src = 2'd0;
    if (!r && awin) begin e.addr = ard; e.data = ad; e.src = 2'd1; end
    else if (!r && lwin) begin e.addr = lrd; e.data = ld; e.src = 2'd2; end
    exp_q.push_back(e);
    if (r) losses = 0;
    else if (areq && !awin) losses = (losses < SL) ? losses + 1 : SL;
    else losses = 0;
    ar = alu_ready_o;
    lr = lsu_ready_o;
  endtask

  task automatic idle(input int n);
    logic a, l;
    for (int i = 0; i < n; i++) step(0, 0, 'x, 'x, 0, 'x, 'x, a, l);
  endtask

  // Monitor: the port presents a value every cycle; compare it with the
  // oldest expectation.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("w_addr", 64'(w_addr_o), 64'(e.addr));
      check("din", 64'(din_o), 64'(e.data));
      check("grant_src", 64'(grant_src_o), 64'(e.src));
      if (w_addr_o !== 5'd0 && !$isunknown(w_addr_o)) port_rf[w_addr_o] = din_o;
    end
  end

  initial begin
    logic a, l;
    logic apend, lpend;
    logic [4:0] ard, lrd;
    logic [DW-1:0] ad, ld;

    rst_i = 1'b1; alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    alu_rd_i = '0; lsu_rd_i = '0; alu_data_i = '0; lsu_data_i = '0;

    // Reset held two cycles with both sources requesting.
    step(1, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, a, l);
    step(1, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, a, l);
    idle(1);

    // Single ALU write.
    step(0, 1, 5'd5, 32'h1234, 0, 'x, 'x, a, l);
    idle(1);

    // Contention: ALU rd=1 held, fresh LSU requests every cycle.
    a = 1'b0;
    for (int i = 0; i < 8 && !a; i++)
      step(0, 1, 5'd1, 32'hA100, 1, 5'(2 + i), 32'hB000 + i, a, l);
    check("alu_granted_after_starve", 64'(a), 64'd1);
    idle(1);

    // rd=0 from ALU is consumed alongside an LSU write.
    step(0, 1, 5'd0, 32'hDEAD, 1, 5'd7, 32'h77, a, l);
    idle(1);

    // Same destination from both: LSU first, ALU value persists.
    step(0, 1, 5'd9, 32'hBB, 1, 5'd9, 32'hAA, a, l);
    step(0, 1, 5'd9, 32'hBB, 0, 'x, 'x, a, l);
    idle(2);
    check("r9_final", 64'(port_rf[9]), 64'h0000_00BB);

    // Reset directly after a grant drops the in-flight write.
    step(0, 1, 5'd1, 32'h5, 1, 5'd2, 32'h6, a, l);
    step(1, 1, 5'd1, 32'h5, 0, 'x, 'x, a, l);
    idle(2);

    // Random traffic, requesters hold until accepted.
    apend = 0; lpend = 0;
    ard = '0; lrd = '0; ad = '0; ld = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!apend && $urandom_range(0, 2) != 0) begin
        apend = 1;
        ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ad = $urandom;
      end
      if (!lpend && $urandom_range(0, 2) != 0) begin
        lpend = 1;
        lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ld = $urandom;
      end
      step(($urandom_range(0, 99) == 0),
           apend, apend ? ard : 5'bx, ad,
           lpend, lpend ? lrd : 5'bx, ld, a, l);
      if (a) apend = 0;
      if (l) lpend = 0;
    end
    idle(2);
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
